// File: rtl/charmap_pkg.sv
// Purpose : shared constants for the character-map renderer: register map,
//           ctrl bit positions, 16-entry CGA palette and RGB332 expansion.
// Latency : n/a (package only).
// Stall   : n/a (package only).
package charmap_pkg;

    // Register port addresses.
    localparam logic [2:0] REG_SCROLL_X = 3'd0;
    localparam logic [2:0] REG_SCROLL_Y = 3'd1;
    localparam logic [2:0] REG_CTRL     = 3'd2;
    localparam logic [2:0] REG_BG       = 3'd3;
    localparam logic [2:0] REG_CUR_COL  = 3'd4;
    localparam logic [2:0] REG_CUR_ROW  = 3'd5;

    // ctrl register bit positions.
    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    // CGA ordering, {R,G,B} 8 bits each.
    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    // RGB332 byte to {R,G,B}. Red sits in the low bits of the byte,
    // blue in the top two; each field is replicated to fill 6 bits.
    function automatic logic [23:0] rgb332_expand(input logic [7:0] c);
        return {c[2:0], c[2:0], 2'b00,
                c[5:3], c[5:3], 2'b00,
                c[7:6], c[7:6], c[7:6], 2'b00};
    endfunction

endpackage

// File: rtl/charmap_delay.sv
// Purpose : ce-gated shift register carrying sync/blank and per-pixel sidebands.
// Latency : DEPTH ce cycles from data to delayed.
// Stall   : holds every stage while ce is low.
// Ports   : clk_sys, reset (sync, active-high), ce, data[WIDTH], delayed[WIDTH].
module charmap_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
            stage[0] <= data;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/charmap_renderer.sv
// Purpose : character-map text renderer: beam counters -> char/colour/font
//           fetches -> RGB, with scroll, frame-synced registers and palette.
// Latency : 3 ce_pix from hcnt/vcnt to RGB; blank/sync delayed to match.
// Stall   : whole pipeline holds while ce_pix is low; register port never stalls.
// Ports   : clk_sys/reset/ce_pix; beam hcnt,vcnt,hb/vb/hs/vs_in; map RAM
//           map_addr -> map_data,col_data; font ROM font_addr -> font_data;
//           register port reg_wr/reg_addr/reg_data; r/g/b_out, hb/vb/hs/vs_out.
// Option  : define CHARMAP_CURSOR_EN for a blinking inverted-cell cursor
//           (registers 4 cursor_col, 5 cursor_row).
module charmap_renderer
    import charmap_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int ROWS    = 32,
    parameter int CHAR_H  = 8,
    parameter int MAP_AW  = $clog2(COLS*ROWS),
    parameter int FONT_AW = 8 + $clog2(CHAR_H)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic [8:0]         hcnt,
    input  logic [8:0]         vcnt,
    input  logic               hb_in,
    input  logic               vb_in,
    input  logic               hs_in,
    input  logic               vs_in,
    output logic [MAP_AW-1:0]  map_addr,
    input  logic [7:0]         map_data,
    input  logic [7:0]         col_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic               reg_wr,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         reg_data,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out,
    output logic               hb_out,
    output logic               vb_out,
    output logic               hs_out,
    output logic               vs_out
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int LW  = $clog2(CHAR_H);
    localparam int VXW = CW + 3;
    localparam int VYW = RW + LW;

    // ---------------- register file: shadow + frame-synced active copy
    logic [7:0] sh_scroll_x, sh_scroll_y, sh_bg;
    logic [7:0] act_scroll_x, act_scroll_y, act_bg;
    logic [1:0] sh_ctrl, act_ctrl;
    logic       vb_q;
    logic       frame_rise;

    assign frame_rise = vb_in & ~vb_q;

    // vb_q resets high so a vb_in already high at reset release is not
    // mistaken for a fresh frame edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vb_q         <= 1'b1;
            sh_scroll_x  <= '0;
            sh_scroll_y  <= '0;
            sh_ctrl      <= '0;
            sh_bg        <= '0;
            act_scroll_x <= '0;
            act_scroll_y <= '0;
            act_ctrl     <= '0;
            act_bg       <= '0;
        end else begin
            vb_q <= vb_in;
            if (reg_wr) begin
                case (reg_addr)
                    REG_SCROLL_X: sh_scroll_x <= reg_data;
                    REG_SCROLL_Y: sh_scroll_y <= reg_data;
                    REG_CTRL:     sh_ctrl     <= reg_data[1:0];
                    REG_BG:       sh_bg       <= reg_data;
                    default:      ;
                endcase
            end
            // Non-blocking read of the shadows: a write on this same cycle
            // lands in the shadow only and takes effect next frame.
            if (frame_rise) begin
                act_scroll_x <= sh_scroll_x;
                act_scroll_y <= sh_scroll_y;
                act_ctrl     <= sh_ctrl;
                act_bg       <= sh_bg;
            end
        end
    end

    // ---------------- S0: virtual coordinates, map address
    logic [VXW-1:0] vx;
    logic [VYW-1:0] vy;
    logic [LW-1:0]  line0;
    logic           cur_hit;

    // Truncating to the map size gives the modulo wrap for free.
    assign vx = VXW'(hcnt) + VXW'(act_scroll_x);
    assign vy = VYW'(vcnt) + VYW'(act_scroll_y);

`ifdef CHARMAP_CURSOR_EN
    logic [7:0] sh_cur_col, sh_cur_row, act_cur_col, act_cur_row;
    logic [5:0] frame_cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sh_cur_col  <= '0;
            sh_cur_row  <= '0;
            act_cur_col <= '0;
            act_cur_row <= '0;
            frame_cnt   <= '0;
        end else begin
            if (reg_wr && reg_addr == REG_CUR_COL) sh_cur_col <= reg_data;
            if (reg_wr && reg_addr == REG_CUR_ROW) sh_cur_row <= reg_data;
            if (frame_rise) begin
                act_cur_col <= sh_cur_col;
                act_cur_row <= sh_cur_row;
                frame_cnt   <= frame_cnt + 6'd1;
            end
        end
    end

    // Visible during the first 32 frames of each 64-frame period.
    assign cur_hit = ~frame_cnt[5]
                   && (8'(vx[VXW-1:3])  == act_cur_col)
                   && (8'(vy[VYW-1:LW]) == act_cur_row);
`else
    assign cur_hit = 1'b0;
`endif

    // Sidebands ride two stages (S0, S1) and are consumed by S2.
    logic [7:0] side;
    logic       s1_hb, s1_vb, s1_hs, s1_vs, s1_cur;
    logic [2:0] s1_px;

    charmap_delay #(
        .WIDTH  (8),
        .DEPTH  (2),
        .RST_VAL(8'b1100_0000)
    ) u_delay (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ce     (ce_pix),
        .data   ({hb_in, vb_in, hs_in, vs_in, vx[2:0], cur_hit}),
        .delayed(side)
    );

    assign {s1_hb, s1_vb, s1_hs, s1_vs, s1_px, s1_cur} = side;

    // ---------------- S0/S1 fetch registers
    logic [7:0] col1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            map_addr  <= '0;
            line0     <= '0;
            font_addr <= '0;
            col1      <= '0;
        end else if (ce_pix) begin
            map_addr  <= {vy[VYW-1:LW], vx[VXW-1:3]};
            line0     <= vy[LW-1:0];
            font_addr <= {map_data, line0};
            col1      <= col_data;
        end
    end

    // ---------------- S2: pixel select, colour, output registers
    logic        pix;
    logic [23:0] fg, bg, rgb;

    always_comb begin
        // ~px == 7 - px: bit 7 is the leftmost pixel.
        pix = font_data[~s1_px] ^ s1_cur;
        if (act_ctrl[CTRL_MODE]) begin
            fg = PALETTE[col1[3:0]];
            bg = PALETTE[col1[7:4]];
        end else begin
            fg = rgb332_expand(col1);
            bg = rgb332_expand(act_bg);
        end
        rgb = pix ? fg : bg;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            hb_out <= 1'b1;
            vb_out <= 1'b1;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else if (ce_pix) begin
            if (s1_hb || s1_vb || !act_ctrl[CTRL_EN]) begin
                {r_out, g_out, b_out} <= '0;
            end else begin
                {r_out, g_out, b_out} <= rgb;
            end
            hb_out <= s1_hb;
            vb_out <= s1_vb;
            hs_out <= s1_hs;
            vs_out <= s1_vs;
        end
    end

endmodule
